// File: rtl/fp_mult.sv
// fp_mult: two-stage pipelined IEEE-754 binary32 multiplier.
//   Round to nearest, ties to even. Zero, infinity and NaN are handled.
//   Subnormal inputs and outputs are flushed to signed zero.
//   Every NaN result is the canonical quiet NaN 0x7FC00000.
//   Latency is 2 clocks and one operation is accepted per clock.
//   There is no stall: the data registers load on every edge, and
//   in_valid travels alongside the data as a valid bit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every pipeline register
//   in_valid   operand pair is valid this cycle
//   operand_a  multiplicand, binary32
//   operand_b  multiplier, binary32
//   out_valid  result is valid this cycle
//   result     product, binary32 (don't-care while out_valid = 0)
module fp_mult (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        out_valid,
  output logic [31:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------- stage 1: decode, multiply, exponent sum ----------------
  logic       sign_a, sign_b;
  logic [7:0] exp_a, exp_b;
  logic [22:0] frac_a, frac_b;

  assign sign_a = operand_a[31];
  assign sign_b = operand_b[31];
  assign exp_a  = operand_a[30:23];
  assign exp_b  = operand_b[30:23];
  assign frac_a = operand_a[22:0];
  assign frac_b = operand_b[22:0];

  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  // An exponent field of 0 counts as zero whatever the fraction holds, which flushes subnormals.
  assign a_zero = (exp_a == 8'h00);
  assign b_zero = (exp_b == 8'h00);
  assign a_inf  = (exp_a == 8'hFF) && (frac_a == 23'd0);
  assign b_inf  = (exp_b == 8'hFF) && (frac_b == 23'd0);
  assign a_nan  = (exp_a == 8'hFF) && (frac_a != 23'd0);
  assign b_nan  = (exp_b == 8'hFF) && (frac_b != 23'd0);

  logic        sign_c;
  logic        special_c;
  logic [31:0] special_res_c;
  logic [47:0] prod_c;
  logic signed [9:0] exp_c;

  assign sign_c = sign_a ^ sign_b;

  always_comb begin
    special_c     = 1'b1;
    special_res_c = 32'd0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      special_res_c = QNAN;
    end else if (a_inf || b_inf) begin
      special_res_c = {sign_c, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special_res_c = {sign_c, 31'd0};
    end else begin
      special_c = 1'b0;
    end
  end

  // Special operands still go through the multiplier here. Stage 2 discards
  // that product whenever the special flag is set.
  assign prod_c = 48'({1'b1, frac_a}) * 48'({1'b1, frac_b});

  // The biased sum minus the bias ranges from -125 to 381, so it fits a 10-bit signed value.
  assign exp_c = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

  logic              s1_valid;
  logic              s1_sign;
  logic              s1_special;
  logic [31:0]       s1_special_res;
  logic [47:0]       s1_prod;
  logic signed [9:0] s1_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_res <= 32'd0;
      s1_prod        <= 48'd0;
      s1_exp         <= 10'sd0;
    end else begin
      s1_valid       <= in_valid;
      s1_sign        <= sign_c;
      s1_special     <= special_c;
      s1_special_res <= special_res_c;
      s1_prod        <= prod_c;
      s1_exp         <= exp_c;
    end
  end

  // ---------------- stage 2: normalize, round, range check ----------------
  logic              norm_hi;
  logic [22:0]       mant;
  logic              guard_bit, sticky_bit, round_up;
  logic [23:0]       mant_rnd;
  logic signed [9:0] exp_fin;
  logic [31:0]       res_c;

  // A product of two significands in [1,2) falls in [1,4). When bit 47 is set the product is at least 2, so shift one more place.
  assign norm_hi    = s1_prod[47];
  assign mant       = norm_hi ? s1_prod[46:24] : s1_prod[45:23];
  assign guard_bit  = norm_hi ? s1_prod[23] : s1_prod[22];
  assign sticky_bit = norm_hi ? (|s1_prod[22:0]) : (|s1_prod[21:0]);
  assign round_up   = guard_bit & (sticky_bit | mant[0]);

  // A carry out of the fraction leaves mant_rnd[22:0] all zero, which is the required fraction.
  assign mant_rnd = {1'b0, mant} + {23'd0, round_up};
  assign exp_fin  = s1_exp + $signed({9'd0, norm_hi}) + $signed({9'd0, mant_rnd[23]});

  always_comb begin
    res_c = {s1_sign, exp_fin[7:0], mant_rnd[22:0]};
    if (s1_special) begin
      res_c = s1_special_res;
    end else if (exp_fin >= 10'sd255) begin
      res_c = {s1_sign, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      res_c = {s1_sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= 32'd0;
    end else begin
      out_valid <= s1_valid;
      result    <= res_c;
    end
  end

endmodule

// File: tb/tb_fp_mult.sv
module tb_fp_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        out_valid;
  logic [31:0] result;

  int checks;
  int failures;

  fp_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiply for normal operands whose product stays in range. It works in
  // double precision, where a 24x24-bit product is exact, and rounds to 24 bits ties-to-even.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    real y, fl, fr;
    int  e2, ea, eb, ma, mb, fi, biased;
    logic [31:0] fw, bw;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = int'(a[22:0]) + 8388608;
    mb = int'(b[22:0]) + 8388608;
    y  = $itor(ma) * $itor(mb);
    e2 = ea + eb - 300;
    while (y >= 16777216.0) begin
      y  = y / 2.0;
      e2 = e2 + 1;
    end
    while (y < 8388608.0) begin
      y  = y * 2.0;
      e2 = e2 - 1;
    end
    fl = $floor(y);
    fr = y - fl;
    fi = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && (fi % 2) == 1)) fl = fl + 1.0;
    if (fl >= 16777216.0) begin
      fl = fl / 2.0;
      e2 = e2 + 1;
    end
    fi = $rtoi(fl) - 8388608;
    biased = e2 + 150;
    fw = 32'(fi);
    bw = 32'(biased);
    return {a[31] ^ b[31], bw[7:0], fw[22:0]};
  endfunction

  // Presents one operand pair, then returns the outputs sampled two clocks later.
  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       output logic v, output logic [31:0] r);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    v = out_valid;
    r = result;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("FAIL reset_result: got %08h expected 00000000", result);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %0b expected 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_valid: got %0b expected 0", out_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    logic        v;
    logic [31:0] r;
    av = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
    bv = '{32'h3F800000, 32'h40000000, 32'h3FFFFFFF, 32'h3FC00000};
    ev = '{32'h3F800000, 32'h40000000, 32'h3FFFFFFF, 32'h40100000};
    for (int i = 0; i < 4; i++) begin
      apply(av[i], bv[i], v, r);
      checks++;
      if (v !== 1'b1) begin
        failures++;
        $display("FAIL basic_valid[%0d]: got %0b expected 1", i, v);
      end
      checks++;
      if (r !== ev[i]) begin
        failures++;
        $display("FAIL basic[%0d]: %08h x %08h got %08h expected %08h", i, av[i], bv[i], r, ev[i]);
      end
    end
  endtask

  task automatic test_zeros();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    logic        v;
    logic [31:0] r;
    av = '{32'h3FC00000, 32'h00000000, 32'h80000000, 32'h80000000};
    bv = '{32'h00000000, 32'h3FC00000, 32'h3FC00000, 32'hBFC00000};
    ev = '{32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      apply(av[i], bv[i], v, r);
      checks++;
      if (v !== 1'b1 || r !== ev[i]) begin
        failures++;
        $display("FAIL zero[%0d]: %08h x %08h got %08h (valid %0b) expected %08h", i, av[i], bv[i], r, v, ev[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [31:0] ev [6];
    logic        v;
    logic [31:0] r;
    av = '{32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h7F000000, 32'h00800000, 32'h00000001};
    bv = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    ev = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      apply(av[i], bv[i], v, r);
      checks++;
      if (v !== 1'b1 || r !== ev[i]) begin
        failures++;
        $display("FAIL special[%0d]: %08h x %08h got %08h (valid %0b) expected %08h", i, av[i], bv[i], r, v, ev[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    logic        v;
    logic [31:0] r;
    // Entry 2: 1.5 x (1 + 2^-23) = 1.5 + 1.5*2^-23, so the guard is set and the sticky is clear. The tie goes up to the even 0x3FC00002.
    // Entry 3: 1.25 x (1 + 2^-23) = 1.25 + 1.25*2^-23, so the guard is clear and the result rounds down to 0x3FA00001.
    av = '{32'h3F800001, 32'h3FFFFFFF, 32'h3FC00000, 32'h3FA00000};
    bv = '{32'h3F800001, 32'h3FFFFFFF, 32'h3F800001, 32'h3F800001};
    ev = '{32'h3F800002, 32'h407FFFFE, 32'h3FC00002, 32'h3FA00001};
    for (int i = 0; i < 4; i++) begin
      apply(av[i], bv[i], v, r);
      checks++;
      if (v !== 1'b1 || r !== ev[i]) begin
        failures++;
        $display("FAIL round[%0d]: %08h x %08h got %08h (valid %0b) expected %08h", i, av[i], bv[i], r, v, ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] ev [8];
    for (int i = 0; i < 8; i++) begin
      av[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      bv[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      ev[i] = ref_mul(av[i], bv[i]);
    end
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i >= 2 && i < 10) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_valid[%0d]: got %0b expected 1", i - 2, out_valid);
        end
        checks++;
        if (result !== ev[i-2]) begin
          failures++;
          $display("FAIL b2b[%0d]: %08h x %08h got %08h expected %08h", i - 2, av[i-2], bv[i-2], result, ev[i-2]);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle[%0d]: got %0b expected 0", i, out_valid);
        end
      end
      if (i < 8) begin
        operand_a = av[i];
        operand_b = bv[i];
        in_valid  = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (out_valid !== pat[i-2]) begin
          failures++;
          $display("FAIL toggle[%0d]: got %0b expected %0b", i - 2, out_valid, pat[i-2]);
        end
      end
      operand_a = 32'h40400000;
      operand_b = 32'h40000000;
      in_valid  = pat[i];
    end
  endtask

  task automatic test_reset_mid_stream();
    logic        v;
    logic [31:0] r;
    @(negedge clk);
    operand_a = 32'h3F800000;
    operand_b = 32'h40000000;
    in_valid  = 1'b1;
    @(negedge clk);
    operand_a = 32'h40400000;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: got valid %0b result %08h expected 0 00000000", out_valid, result);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_valid[%0d]: got %0b expected 0", i, out_valid);
      end
    end
    apply(32'h40400000, 32'h40000000, v, r);
    checks++;
    if (v !== 1'b1 || r !== 32'h40C00000) begin
      failures++;
      $display("FAIL post_reset: got %08h (valid %0b) expected 40C00000", r, v);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    operand_a = 32'h0;
    operand_b = 32'h0;
    void'($urandom(32'h1234_5678));
    test_reset();
    test_basic();
    test_zeros();
    test_specials();
    test_rounding();
    test_back_to_back();
    test_valid_toggle();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_mult.md
# fp_mult

Pipelined IEEE-754 single-precision floating-point multiplier for the FPU datapath. It accepts one operand pair per clock and returns the correctly signed, round-to-nearest-even product two cycles later. Special values are handled: zero, infinity and NaN. Subnormal inputs and outputs are flushed to zero. Results feed the FPU result mux directly.

## Interface
- No parameters. Format fixed to binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair on operand_a/operand_b is valid this cycle
- operand_a  input  32  multiplicand, binary32
- operand_b  input  32  multiplier, binary32
- out_valid  output  1  result is valid this cycle
- result  output  32  product, binary32

## Operation
- Sign of the result = sign_a XOR sign_b for every class, including zero and infinity.
  - Exception: NaN results always use the canonical quiet NaN 0x7FC00000.
- Input classification is by exponent field e and fraction f:
  - e=0: zero. Subnormals (f≠0) are flushed to zero.
  - e=255, f=0: infinity.
  - e=255, f≠0: NaN.
  - Otherwise: normal.
- Special-case priority:
  1. Either input NaN → 0x7FC00000.
  2. Infinity × zero → 0x7FC00000.
  3. Either input infinity → signed infinity (exponent 0xFF, fraction 0).
  4. Either input zero → signed zero.
  5. Otherwise use the normal path.
- Normal path:
  - Significands: ma = {1,fa}, mb = {1,fb}, each 24 bits. Product p = ma×mb, 48 bits unsigned.
  - Exponent: exp = ea + eb − 127, held in a 10-bit signed intermediate.
  - If p[47]=1: mantissa = p[46:24], guard = p[23], sticky = OR(p[22:0]), exp += 1.
  - If p[47]=0: mantissa = p[45:23], guard = p[22], sticky = OR(p[21:0]).
  - Round to nearest, ties to even: increment the mantissa when guard & (sticky | mantissa[0]).
  - If rounding carries out of the 23-bit fraction: fraction = 0 and exp += 1.
- Final exponent:
  - exp ≥ 255 → signed infinity (overflow).
  - exp ≤ 0 → signed zero (underflow flush; no subnormal output).
  - Otherwise result = {sign, exp[7:0], fraction}.
- No exception flags are produced.

## Timing
- Fully pipelined, two register stages. Latency is exactly 2 clocks; throughput is 1 operation per clock.
- Stage 1 registers:
  - special-case decode, with the special result pre-selected;
  - sign;
  - 48-bit product;
  - pre-normalized exponent;
  - a stage valid bit.
- Stage 2 performs normalize, round and overflow/underflow, then registers result and out_valid.
- Pipeline advance and valid bits:
  - The pipeline always advances; there is no stall or backpressure.
  - in_valid only propagates as a valid bit, 2 cycles to out_valid.
  - Data registers capture every cycle regardless of in_valid.
  - result is don't-care when out_valid=0.
- Reset:
  - rst_n low asynchronously clears every pipeline register: result=0x00000000, out_valid=0.
  - Reset asserted mid-operation discards all in-flight operations.
  - After rst_n deasserts, the first out_valid can occur no earlier than 2 rising edges after the first in_valid is sampled.
- Back-to-back inputs with in_valid held high produce consecutive results in the same order with no bubbles.

## Test plan
- Basic products, each pair presented with in_valid=1, result checked 2 cycles later with out_valid=1:
  - 0x3F800000 × 0x3F800000 → 0x3F800000
  - 0x3F800000 × 0x40000000 → 0x40000000
  - 0x3F800000 × 0x3FFFFFFF → 0x3FFFFFFF
  - 0x3FC00000 × 0x3FC00000 → 0x40100000
- Zeros:
  - 0x3FC00000 × 0x00000000 → 0x00000000
  - 0x00000000 × 0x3FC00000 → 0x00000000
  - 0x80000000 × 0x3FC00000 → 0x80000000
  - 0x80000000 × 0xBFC00000 → 0x00000000
- Specials and range limits:
  - 0x7F800000 × 0x00000000 → 0x7FC00000
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000
  - 0xFF800000 × 0x40000000 → 0xFF800000
  - 0x7F000000 × 0x40000000 → 0x7F800000 (overflow)
  - 0x00800000 × 0x3F000000 → 0x00000000 (underflow flush)
  - 0x00000001 × 0x3F800000 → 0x00000000 (subnormal input)
- Rounding:
  - 0x3F800001 × 0x3F800001 → 0x3F800002 (round down, below half)
  - 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE (normalization shift)
- Pipeline:
  - Drive 8 random normal pairs back-to-back with in_valid=1 → out_valid high for 8 consecutive cycles starting 2 cycles later, each result matching a software reference.
  - Toggle in_valid 1,0,1 → out_valid shows the same 1,0,1 pattern delayed by 2 cycles.
- Reset: assert rst_n=0 asynchronously mid-stream (between clock edges) → result=0x00000000 and out_valid=0 immediately, with no stale valid after release.
